lcd_bus_monitor: RTL
====================

LCD_BUS_MONITOR -- requirements
Module: lcd_bus_monitor

Interface
REQ-001 Parameter SYNC_STAGES, default 2: number of synchronizer flops on every LCD bus input.
REQ-002 Parameter CLR_CHAR, default 8'h20: fill character written by clear and by reset.
REQ-003 Port clock  input  1: single system clock (CLOCK_50 domain); all state updates on its rising edge.
REQ-004 Port reset  input  1: synchronous, active-high reset.
REQ-005 Port lcd_data  input  8: HD44780 data bus as driven by LCD_Display.
REQ-006 Port lcd_rs  input  1: register select (0 = command, 1 = data).
REQ-007 Port lcd_rw  input  1: read/write (0 = write).
REQ-008 Port lcd_en  input  1: enable strobe; the transfer is captured on its falling edge.
REQ-009 Port rd_addr  input  5: character buffer read index (0-15 = line 1, 16-31 = line 2).
REQ-010 Port rd_char  output  8: buffer content at rd_addr, combinational read.
REQ-011 Port cursor  output  5: current buffer write index.
REQ-012 Port busy  output  1: high while a clear sweep is in progress.
REQ-013 Port evt  output  1: one-cycle pulse per accepted write transfer.
REQ-014 Port char_count  output  16: number of data characters written, saturating at 16'hFFFF.
REQ-015 Port err  output  2: sticky flags; bit0 = bad DDRAM address, bit1 = transfer dropped while busy.

Function
REQ-016 lcd_en, lcd_rs, lcd_rw and lcd_data SHALL each pass through SYNC_STAGES flops before use.
REQ-017 While synced EN = 1, rs/rw/data SHALL be latched every cycle; a strobe SHALL fire on the cycle synced EN goes 1->0 and SHALL use the latched values.
REQ-018 A strobe with rw = 1 SHALL be ignored: no state change and no evt.
REQ-019 FSM states: IDLE, CLEAR. IDLE -> CLEAR on a clear command; CLEAR -> IDLE after index 31 has been written.
REQ-020 CLEAR SHALL write CLR_CHAR to one buffer entry per cycle, indices 0..31, for exactly 32 cycles; busy = 1 throughout and cursor = 0 on exit.
REQ-021 Data write (rs = 1, IDLE): buffer[cursor] <= data, cursor <= cursor + 1 with 31 wrapping to 0, char_count increments, evt = 1.
REQ-022 Command 8'h01 SHALL enter CLEAR and assert evt.
REQ-023 Command 8'b0000001x (return home) SHALL set cursor to 0 and assert evt.
REQ-024 Command 1aaaaaaa (set DDRAM address): a[6] selects the line, a[3:0] the column, cursor <= {a[6], a[3:0]}; if a[5:4] != 0, err[0] SHALL be set, cursor SHALL be unchanged, and evt SHALL still be asserted.
REQ-025 All other commands (function set, entry mode, display control, shift) SHALL assert evt and cause no other state change.
REQ-026 A strobe arriving while busy SHALL be dropped with no evt, err[1] SHALL be set, and the sweep SHALL continue unaffected.
REQ-027 A data write to index 15 SHALL advance cursor to 16; the monitor does not emulate the hidden DDRAM addresses 0x10-0x3F.
REQ-028 rd_char SHALL reflect a buffer write on the cycle after that write.

Reset
REQ-029 Reset SHALL set cursor = 0, char_count = 0, err = 0 and evt = 0, clear the EN edge history and synchronizers to 0, and force state CLEAR.
REQ-030 After reset is released, busy SHALL stay high for exactly 32 cycles, and all entries SHALL then read CLR_CHAR.
REQ-031 Reset asserted mid-sweep or mid-strobe SHALL restart the sweep at index 0 and discard any pending strobe.

Verification
REQ-032 Release reset, wait 32 cycles -> busy falls, all 32 rd_char = 8'h20, cursor = 0.
REQ-033 Write data 'A' (8'h41) then 'B' (8'h42) -> index0 = 8'h41, index1 = 8'h42, cursor = 2, char_count = 2, two evt pulses.
REQ-034 Command 8'hC5, then data 8'h5A -> index 21 = 8'h5A, cursor = 22; command 8'hA0 -> err[0] = 1, cursor = 22.
REQ-035 Command 8'h01, then a data strobe 5 cycles later -> err[1] = 1, that data is not stored, busy lasts 32 cycles, cursor = 0.
REQ-036 Set address 8'hCF, write 2 characters -> index 31 written, then index 0 written, cursor = 1.
REQ-037 Strobe with rw = 1, plus EN glitches shorter than the SYNC_STAGES delay held stable -> no evt, buffer and counters unchanged.

Source files
------------

// File: rtl/lcd_bus_monitor.sv
// ---------------------------------------------------------------------------
// lcd_bus_monitor
//
// Passive snooper for an HD44780-style 2x16 character LCD bus. It mirrors the
// characters the host writes into a 32-entry shadow buffer so other logic can
// read back what is on the display.
//
// Ports
//   clock       system clock; every state update happens on its rising edge
//   reset       synchronous, active-high; restarts the clear sweep
//   lcd_data    8-bit LCD data bus (asynchronous to clock)
//   lcd_rs      register select, 0 = command, 1 = data
//   lcd_rw      read/write, 0 = write (reads are ignored)
//   lcd_en      enable strobe; a transfer is taken on its falling edge
//   rd_addr     shadow buffer read index (0-15 line 1, 16-31 line 2)
//   rd_char     buffer content at rd_addr (combinational read)
//   cursor      current buffer write index
//   busy        high while the clear sweep runs
//   evt         one-cycle pulse per accepted write transfer
//   char_count  number of data characters written, saturating
//   err         sticky flags: [0] bad DDRAM address, [1] transfer dropped
// ---------------------------------------------------------------------------
module lcd_bus_monitor #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] CLR_CHAR    = 8'h20
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  lcd_data,
  input  logic        lcd_rs,
  input  logic        lcd_rw,
  input  logic        lcd_en,
  input  logic [4:0]  rd_addr,
  output logic [7:0]  rd_char,
  output logic [4:0]  cursor,
  output logic        busy,
  output logic        evt,
  output logic [15:0] char_count,
  output logic [1:0]  err
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  // Bus bundle layout: {en, rs, rw, data[7:0]}
  logic [10:0] w_bus_in;
  logic [10:0] w_bus_s;
  logic [10:0] r_sync [SYNC_STAGES];

  logic        w_en_s;
  logic        r_en_prev;
  logic        r_lat_rs;
  logic        r_lat_rw;
  logic [7:0]  r_lat_data;

  logic [0:0]  r_state;
  logic [4:0]  r_clr_idx;
  logic [4:0]  r_cursor;
  logic [15:0] r_char_count;
  logic [1:0]  r_err;
  logic        r_evt;

  logic [7:0]  r_buf [32];

  logic        w_strobe;
  logic        w_accept;
  logic        w_drop;
  logic        w_is_clear;
  logic        w_is_home;
  logic        w_is_addr;
  logic        w_addr_bad;
  logic        w_we;
  logic [4:0]  w_waddr;
  logic [7:0]  w_wdata;

  assign w_bus_in = {lcd_en, lcd_rs, lcd_rw, lcd_data};
  assign w_bus_s  = r_sync[SYNC_STAGES-1];
  assign w_en_s   = w_bus_s[10];

  // Every bus line goes through the same number of flops so the latched
  // rs/rw/data stay aligned with the synchronized enable.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        r_sync[i] <= '0;
      end
    end else begin
      r_sync[0] <= w_bus_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  // Falling edge of the synchronized enable; the transfer uses the values
  // latched during the last cycle enable was high.
  assign w_strobe = r_en_prev & ~w_en_s;
  assign w_accept = w_strobe & ~r_lat_rw & (r_state == ST_IDLE);
  assign w_drop   = w_strobe & ~r_lat_rw & (r_state == ST_CLEAR);

  assign w_is_clear = (r_lat_data == 8'h01);
  assign w_is_home  = (r_lat_data[7:1] == 7'b0000001);
  assign w_is_addr  = r_lat_data[7];
  assign w_addr_bad = |r_lat_data[5:4];

  always_ff @(posedge clock) begin
    if (reset) begin
      r_en_prev    <= 1'b0;
      r_lat_rs     <= 1'b0;
      r_lat_rw     <= 1'b0;
      r_lat_data   <= 8'h00;
      r_state      <= ST_CLEAR;
      r_clr_idx    <= 5'd0;
      r_cursor     <= 5'd0;
      r_char_count <= 16'd0;
      r_err        <= 2'b00;
      r_evt        <= 1'b0;
    end else begin
      r_en_prev <= w_en_s;
      if (w_en_s) begin
        r_lat_rs   <= w_bus_s[9];
        r_lat_rw   <= w_bus_s[8];
        r_lat_data <= w_bus_s[7:0];
      end

      r_evt <= w_accept;

      if (w_drop) begin
        r_err[1] <= 1'b1;
      end

      case (r_state)
        ST_CLEAR: begin
          r_clr_idx <= r_clr_idx + 5'd1;
          if (r_clr_idx == 5'd31) begin
            r_state  <= ST_IDLE;
            r_cursor <= 5'd0;
          end
        end
        default: begin
          if (w_accept) begin
            if (r_lat_rs) begin
              // 5-bit cursor wraps 31 -> 0 naturally; 15 -> 16 jumps lines
              r_cursor <= r_cursor + 5'd1;
              if (r_char_count != 16'hFFFF) begin
                r_char_count <= r_char_count + 16'd1;
              end
            end else if (w_is_clear) begin
              r_state   <= ST_CLEAR;
              r_clr_idx <= 5'd0;
            end else if (w_is_home) begin
              r_cursor <= 5'd0;
            end else if (w_is_addr) begin
              // Only 0x00-0x0F and 0x40-0x4F map onto visible cells
              if (w_addr_bad) begin
                r_err[0] <= 1'b1;
              end else begin
                r_cursor <= {r_lat_data[6], r_lat_data[3:0]};
              end
            end
          end
        end
      endcase
    end
  end

  // Single write port shared by the clear sweep and data writes
  always_comb begin
    w_we    = 1'b0;
    w_waddr = r_cursor;
    w_wdata = r_lat_data;
    if (!reset) begin
      if (r_state == ST_CLEAR) begin
        w_we    = 1'b1;
        w_waddr = r_clr_idx;
        w_wdata = CLR_CHAR;
      end else if (w_accept && r_lat_rs) begin
        w_we = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (w_we) begin
      r_buf[w_waddr] <= w_wdata;
    end
  end

  assign rd_char    = r_buf[rd_addr];
  assign cursor     = r_cursor;
  assign busy       = (r_state == ST_CLEAR);
  assign evt        = r_evt;
  assign char_count = r_char_count;
  assign err        = r_err;

endmodule
